// File: rtl/polar_pkg.sv
// Shared constants, FSM state type and index bit-reversal for the polar encoder
// and the SC decoder bench.
package polar_pkg;
   localparam int LOGN_MAX = 9;
   localparam int LOGN_MIN = 3;
   localparam int N_MAX    = 2 ** LOGN_MAX;
   localparam int OUT_W    = 8;
   localparam int OUT_SH   = $clog2(OUT_W);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ENC, S_OUT} state_e;

   // Reverses the low n bits of v; bits at or above n come back as zero.
   function automatic logic [LOGN_MAX-1:0] bit_rev(input logic [LOGN_MAX-1:0] v,
                                                   input logic [3:0] n);
      logic [LOGN_MAX-1:0] r;
      r = '0;
      for (int j = 0; j < LOGN_MAX; j++)
         if (j < int'(n)) r[int'(n) - 1 - j] = v[j];
      return r;
   endfunction
endpackage

// File: rtl/polar_encoder_if.sv
// Frame input and codeword output handshakes of the polar encoder.
interface polar_encoder_if;
   import polar_pkg::*;

   logic [3:0]       cfg_logn;
   logic             in_valid;
   logic             in_ready;
   logic             in_bit;
   logic             in_frozen;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_data;
   logic             out_last;

   modport master (output cfg_logn, in_valid, in_bit, in_frozen, out_ready,
                   input  in_ready, out_valid, out_data, out_last);
   modport slave  (input  cfg_logn, in_valid, in_bit, in_frozen, out_ready,
                   output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/polar_enc_stage.sv
// One butterfly stage s of the polar transform over the active N = 2**n bits;
// bits at or above N pass through.
module polar_enc_stage
   import polar_pkg::*;
(
   input  logic [N_MAX-1:0] x,
   input  logic [3:0]       s,
   input  logic [3:0]       n,
   output logic [N_MAX-1:0] y
);
   for (genvar i = 0; i < N_MAX; i++) begin : g_bit
      logic [LOGN_MAX-1:0] sel;
      for (genvar st = 0; st < LOGN_MAX; st++) begin : g_st
         // Only the upper-half-of-pair position folds in its partner.
         if (((i >> st) & 1) == 0) begin : g_pair
            assign sel[st] = x[i] ^ x[i + (1 << st)];
         end else begin : g_keep
            assign sel[st] = x[i];
         end
      end
      assign y[i] = (32'(i) < (32'd1 << n)) && (s < 4'(LOGN_MAX)) ? sel[s] : x[i];
   end
endmodule

// File: rtl/polar_encoder.sv
// Non-systematic polar encoder x = u * F^(kron n). Define BIT_REVERSE_EN to stream
// the codeword in bit-reversed index order.
module polar_encoder
   import polar_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   polar_encoder_if.slave bus,
   output logic           busy
);
   localparam int W = LOGN_MAX + 1;

   state_e              state, state_nx;
   logic [N_MAX-1:0]    x, x_stage;
   logic [3:0]          n, stage, n_cfg;
   logic [LOGN_MAX-1:0] idx, beat, pos;
   logic [W-1:0]        n_len;
   logic                in_fire, load_last, beat_last, ubit;

   assign n_cfg = (bus.cfg_logn < 4'(LOGN_MIN)) ? 4'(LOGN_MIN) :
                  (bus.cfg_logn > 4'(LOGN_MAX)) ? 4'(LOGN_MAX) : bus.cfg_logn;
   assign n_len     = W'(1) << n;
   assign load_last = ({1'b0, idx} == n_len - W'(1));
   assign beat_last = ({1'b0, beat} == (n_len >> OUT_SH) - W'(1));
   assign in_fire   = bus.in_valid && (state == S_IDLE || state == S_LOAD);
   assign ubit      = bus.in_bit & ~bus.in_frozen;
   assign busy      = (state != S_IDLE);
   assign bus.out_last = (state == S_OUT) && beat_last;

   polar_enc_stage u_stage (.x(x), .s(stage), .n(n), .y(x_stage));

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nx = S_LOAD;
         end
         S_LOAD: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid && load_last) state_nx = S_ENC;
         end
         S_ENC: if (stage == n - 4'd1) state_nx = S_OUT;
         S_OUT: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready && beat_last) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x     <= '0;
         n     <= '0;
         idx   <= '0;
         stage <= '0;
         beat  <= '0;
      end else begin
         unique case (state)
            S_IDLE: if (in_fire) begin
               n     <= n_cfg;
               x[0]  <= ubit;
               idx   <= LOGN_MAX'(1);
               stage <= '0;
               beat  <= '0;
            end
            S_LOAD: if (in_fire) begin
               x[idx] <= ubit;
               idx    <= idx + LOGN_MAX'(1);
            end
            S_ENC: begin
               x     <= x_stage;
               stage <= stage + 4'd1;
            end
            S_OUT: if (bus.out_ready) beat <= beat + LOGN_MAX'(1);
            default: ;
         endcase
      end
   end

   // Output beat is a direct slice of the vector register, so it holds while stalled.
   always_comb begin
      bus.out_data = '0;
      pos          = '0;
      if (state == S_OUT) begin
         for (int k = 0; k < OUT_W; k++) begin
            pos = {beat[LOGN_MAX-OUT_SH-1:0], OUT_SH'(k)};
`ifdef BIT_REVERSE_EN
            pos = bit_rev(pos, n);
`else
            pos = pos;
`endif
            bus.out_data[k] = x[pos];
         end
      end
   end
endmodule

// File: tb/tb_polar_encoder.sv
// Randomized self-checking bench for polar_encoder against a subset-sum reference model.
module tb_polar_encoder;
   import polar_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic busy;
   int   cyc = 0;
   int   errs = 0, checks = 0;

   polar_encoder_if bus ();
   polar_encoder dut (.clk(clk), .rst(rst), .bus(bus), .busy(busy));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // x_j = XOR of u_i over all i whose bits are a superset of j's bits.
   function automatic logic [7:0] exp_beat(input logic [N_MAX-1:0] u, input int n, input int b);
      logic [7:0] r;
      int j, jj;
      r = '0;
      for (int k = 0; k < 8; k++) begin
         j  = b * 8 + k;
         jj = j;
`ifdef BIT_REVERSE_EN
         jj = 0;
         for (int q = 0; q < n; q++) if (((j >> q) & 1) == 1) jj |= 1 << (n - 1 - q);
`endif
         for (int i = 0; i < (1 << n); i++) if ((i & jj) == jj) r[k] ^= u[i];
      end
      return r;
   endfunction

   function automatic int clamp_n(input int c);
      return (c < 3) ? 3 : (c > 9) ? 9 : c;
   endfunction

   task automatic chk_rst(input string tag);
      chk({tag, "_out_valid"}, bus.out_valid, 0);
      chk({tag, "_out_data"},  bus.out_data,  0);
      chk({tag, "_out_last"},  bus.out_last,  0);
      chk({tag, "_busy"},      busy,          0);
      chk({tag, "_in_ready"},  bus.in_ready,  1);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_rst(tag);
      rst = 1'b0;
   endtask

   task automatic send(input logic [3:0] cfg, input logic [N_MAX-1:0] ub,
                       input logic [N_MAX-1:0] fz, input int nb, input bit gaps,
                       input bit hold, output int t_last);
      int i = 0, g = 0;
      t_last = -1;
      bus.cfg_logn = cfg;
      while (i < nb && g < 4000) begin
         bus.in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
         bus.in_bit    = ub[i];
         bus.in_frozen = fz[i];
         if (i > 0) bus.cfg_logn = 4'($urandom_range(0, 15));
         if (bus.in_valid && bus.in_ready) begin
            t_last = cyc;
            i++;
         end
         @(posedge clk); #1;
         g++;
      end
      if (i < nb) chk("send_timeout", i, nb);
      bus.in_valid = hold;
   endtask

   // mode 0: always ready, 1: toggling (stall first), 2: random
   task automatic recv(input logic [N_MAX-1:0] u, input int n, input int mode,
                       input int t_last, input bit lat);
      int nbeats = (1 << n) / 8;
      int b = 0, g = 0;
      logic [7:0] pd = '0;
      logic pl = 1'b0;
      bit stalled = 1'b0;
      while (!bus.out_valid && g < 100) begin @(posedge clk); #1; g++; end
      chk("first_valid", bus.out_valid, 1);
      if (lat) chk("latency", cyc - t_last, n + 1);
      g = 0;
      while (b < nbeats && g < 2000) begin
         if (stalled) begin
            chk("stall_data", bus.out_data, pd);
            chk("stall_last", bus.out_last, pl);
         end
         chk($sformatf("data_n%0d_b%0d", n, b), bus.out_data, exp_beat(u, n, b));
         chk("last", bus.out_last, (b == nbeats - 1));
         chk("valid", bus.out_valid, 1);
         bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (g % 2 == 1) : 1'($urandom_range(0, 1));
         pd = bus.out_data;
         pl = bus.out_last;
         stalled = !bus.out_ready;
         if (bus.out_ready) b++;
         @(posedge clk); #1;
         g++;
      end
      chk("beats_done", b, nbeats);
      chk("idle_after", {busy, bus.out_valid, bus.in_ready}, 3'b001);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
   endtask

   task automatic run(input int cfg, input logic [N_MAX-1:0] ub, input logic [N_MAX-1:0] fz,
                      input bit gaps, input int mode, input bit lat, input bit hold);
      int n = clamp_n(cfg);
      int t;
      send(4'(cfg), ub, fz, 1 << n, gaps, hold, t);
      recv(ub & ~fz, n, mode, t, lat);
   endtask

   function automatic logic [N_MAX-1:0] rnd_vec();
      logic [N_MAX-1:0] r;
      for (int i = 0; i < N_MAX / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   initial begin
      int t;
      int g;
      bus.in_valid = 0; bus.in_bit = 0; bus.in_frozen = 0; bus.cfg_logn = 4'd3;
      bus.out_ready = 0; rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      chk_rst("reset");
      rst = 1'b0;

      run(3, 512'h80, '0, 0, 0, 1, 0);
      run(3, 512'h01, '0, 0, 0, 1, 0);
      run(3, 512'hFF, '0, 0, 0, 1, 0);
      run(3, 512'hFF, 512'h0F, 0, 0, 1, 0);
      run(4, 512'h1 << 15, '0, 0, 1, 1, 1);
      run(2, rnd_vec(), rnd_vec(), 1, 2, 0, 0);
      run(12, rnd_vec(), rnd_vec(), 1, 2, 0, 0);

      // reset mid-LOAD
      send(4'd4, rnd_vec(), '0, 5, 0, 0, t);
      do_reset("rst_load");
      run(4, rnd_vec(), rnd_vec(), 0, 0, 1, 0);

      // reset mid-OUT
      send(4'd4, rnd_vec(), '0, 16, 0, 0, t);
      g = 0;
      while (!bus.out_valid && g < 100) begin @(posedge clk); #1; g++; end
      chk("pre_rst_valid", bus.out_valid, 1);
      repeat (2) @(posedge clk); #1;
      do_reset("rst_out");
      run(5, rnd_vec(), rnd_vec(), 1, 2, 0, 0);

      for (int f = 0; f < 6; f++)
         run($urandom_range(0, 15), rnd_vec(), rnd_vec(), 1, $urandom_range(0, 2), 0, 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
